// File: rtl/instr_dcd.sv
// Command decoder behind the SPI bridge: turns synchronized byte events into
// single-cycle register read/write strobes and returns read data on data_out.
//
// state   | meaning
// IDLE    | waiting for a command byte
// WR_DATA | write command latched, waiting for the payload byte
// RD_WAIT | read strobe issued, waiting for the register data capture
// RD_DATA | data_out loaded, waiting for the dummy byte that ends the frame
module instr_dcd #(
  parameter int ADDR_W      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic              hi_sel,
  output logic [7:0]        data_write,
  input  logic [7:0]        data_read
);

  typedef enum logic [1:0] {IDLE, WR_DATA, RD_WAIT, RD_DATA} state_t;

  state_t                   state, state_nxt;
  logic [SYNC_STAGES-1:0]   bs_sr;
  logic [SYNC_STAGES-1:0]   cs_sr;
  logic                     bs_d;
  logic                     ev;
  logic                     abort;
  logic                     cap;
  logic                     read_nxt, write_nxt, hi_nxt;
  logic [ADDR_W-1:0]        addr_nxt;
  logic [7:0]               dw_nxt, dout_nxt;

  assign ev    = bs_sr[SYNC_STAGES-1] & ~bs_d;
  assign abort = cs_sr[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      bs_sr      <= '0;
      cs_sr      <= '1;
      bs_d       <= 1'b0;
      state      <= IDLE;
      read       <= 1'b0;
      write      <= 1'b0;
      cap        <= 1'b0;
      addr       <= '0;
      hi_sel     <= 1'b0;
      data_write <= '0;
      data_out   <= '0;
    end else begin
      bs_sr      <= {bs_sr[SYNC_STAGES-2:0], byte_sync};
      cs_sr      <= {cs_sr[SYNC_STAGES-2:0], cs_n};
      bs_d       <= bs_sr[SYNC_STAGES-1];
      state      <= state_nxt;
      read       <= read_nxt;
      write      <= write_nxt;
      // register file answers the cycle after read, so capture one cycle later
      cap        <= read;
      addr       <= addr_nxt;
      hi_sel     <= hi_nxt;
      data_write <= dw_nxt;
      data_out   <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    read_nxt  = 1'b0;
    write_nxt = 1'b0;
    addr_nxt  = addr;
    hi_nxt    = hi_sel;
    dw_nxt    = data_write;
    // capture is independent of the FSM so an abort cannot lose it
    dout_nxt  = cap ? data_read : data_out;
    case (state)
      IDLE: begin
        if (ev && !abort) begin
          addr_nxt = data_in[ADDR_W-1:0];
          hi_nxt   = data_in[ADDR_W];
          if (data_in[7]) begin
            state_nxt = WR_DATA;
          end else begin
            read_nxt  = 1'b1;
            state_nxt = RD_WAIT;
          end
        end
      end
      WR_DATA: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (ev) begin
          dw_nxt    = data_in;
          write_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        if (abort)    state_nxt = IDLE;
        else if (cap) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (abort || ev) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_dcd.sv
// Directed bench for instr_dcd: drives SPI-bridge style byte frames and checks
// strobes, latched fields and read data against hand-computed values.
module tb_instr_dcd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       read, write;
  logic [5:0] addr;
  logic       hi_sel;
  logic [7:0] data_write;
  logic [7:0] data_read = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, overlap = 0;
  int rd_cyc = 0, wr_cyc = 0, dout_cyc = 0;
  logic [5:0] rd_addr = '0, wr_addr = '0;
  logic       rd_hi = 1'b0, wr_hi = 1'b0;
  logic [7:0] wr_data = '0, dout_prev = '0;

  instr_dcd #(.ADDR_W(6), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .byte_sync(byte_sync),
    .data_in(data_in), .data_out(data_out), .read(read), .write(write),
    .addr(addr), .hi_sel(hi_sel), .data_write(data_write),
    .data_read(data_read)
  );

  always #5 clk = ~clk;

  // register file model: one-cycle read latency
  always @(posedge clk) begin
    if (read)
      data_read <= (addr == 6'h12 && !hi_sel) ? 8'hA7 : ({2'b00, addr} ^ 8'h5A);
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (read) begin rd_cnt++; rd_cyc = cyc; rd_addr = addr; rd_hi = hi_sel; end
    if (write) begin
      wr_cnt++; wr_cyc = cyc; wr_addr = addr; wr_hi = hi_sel; wr_data = data_write;
    end
    if (read && write) overlap++;
    if (data_out !== dout_prev) begin dout_cyc = cyc; dout_prev = data_out; end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_cnt = 0; wr_cnt = 0; overlap = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    data_in = b;
    tick(1);
    byte_sync = 1'b1;
    tick(hold);
    byte_sync = 1'b0;
    tick(gap);
  endtask

  task automatic frame_start();
    cs_n = 1'b1; tick(4);
    cs_n = 1'b0; tick(4);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset_outputs", {8'h0, data_out, read, write, addr, hi_sel, data_write},
        32'h0);

    // write frame, byte_sync held 10 clk per byte
    clear_mon();
    frame_start();
    send_byte(8'hC5, 10, 4);
    send_byte(8'h3A, 10, 4);
    chk("wr_count", wr_cnt, 1);
    chk("wr_no_read", rd_cnt, 0);
    chk("wr_addr", wr_addr, 6'h05);
    chk("wr_hi", wr_hi, 1);
    chk("wr_data", wr_data, 8'h3A);
    chk("wr_addr_hold", addr, 6'h05);

    // read frame
    clear_mon();
    frame_start();
    send_byte(8'h12, 5, 4);
    chk("rd_count", rd_cnt, 1);
    chk("rd_addr", rd_addr, 6'h12);
    chk("rd_hi", rd_hi, 0);
    chk("rd_dout", data_out, 8'hA7);
    chk("rd_latency", dout_cyc - rd_cyc, 2);
    send_byte(8'h00, 5, 4);
    chk("rd_dout_hold", data_out, 8'hA7);
    chk("rd_no_write", wr_cnt, 0);
    chk("rd_single", rd_cnt, 1);

    // abort before payload, then a complete frame
    clear_mon();
    frame_start();
    send_byte(8'h81, 5, 4);
    cs_n = 1'b1; tick(5);
    chk("abort_no_write", wr_cnt, 0);
    cs_n = 1'b0; tick(4);
    send_byte(8'h81, 5, 4);
    send_byte(8'h55, 5, 4);
    chk("abort_next_wr", wr_cnt, 1);
    chk("abort_next_addr", wr_addr, 6'h01);
    chk("abort_next_data", wr_data, 8'h55);
    chk("abort_dout_kept", data_out, 8'hA7);

    // reset while in WR_DATA
    clear_mon();
    frame_start();
    send_byte(8'hC5, 5, 4);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("rst_mid_outputs", {8'h0, data_out, read, write, addr, hi_sel, data_write},
        32'h0);
    send_byte(8'hAA, 5, 4);
    chk("rst_mid_no_write", wr_cnt, 0);
    chk("rst_mid_no_read", rd_cnt, 0);
    frame_start();
    send_byte(8'hC5, 5, 4);
    send_byte(8'h3A, 5, 4);
    chk("rst_after_wr", wr_cnt, 1);
    chk("rst_after_addr", wr_addr, 6'h05);
    chk("rst_after_data", wr_data, 8'h3A);

    // back-to-back write then read in one chip-select window
    clear_mon();
    frame_start();
    send_byte(8'h83, 4, 3);
    send_byte(8'hFF, 4, 3);
    send_byte(8'h03, 4, 3);
    send_byte(8'h00, 4, 3);
    chk("b2b_wr", wr_cnt, 1);
    chk("b2b_rd", rd_cnt, 1);
    chk("b2b_overlap", overlap, 0);
    chk("b2b_wr_addr", wr_addr, 6'h03);
    chk("b2b_rd_addr", rd_addr, 6'h03);
    chk("b2b_wr_data", wr_data, 8'hFF);
    chk("b2b_order", (wr_cyc < rd_cyc), 1);
    chk("b2b_dout", data_out, 8'h59);

    // long byte_sync, then fast glitch-free toggling
    clear_mon();
    frame_start();
    send_byte(8'h84, 100, 4);
    send_byte(8'h11, 100, 4);
    chk("long_wr", wr_cnt, 1);
    chk("long_data", wr_data, 8'h11);
    send_byte(8'h86, 3, 3);
    send_byte(8'h22, 3, 3);
    send_byte(8'h87, 3, 3);
    send_byte(8'h33, 3, 3);
    chk("toggle_wr_count", wr_cnt, 3);
    chk("toggle_addr", wr_addr, 6'h07);
    chk("toggle_data", wr_data, 8'h33);
    chk("toggle_no_read", rd_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
